// File: rtl/hazard_ctrl.sv
// Pipeline hazard/flush controller: stall and clear controls for PC, IF/ID,
// ID/EX, EX/MEM and MEM/WB covering load-use, redirect and data-memory wait.
// Ports:
//   clk, rst (sync, active-high)
//   id_rs1/id_rs2/id_uses_rs1/id_uses_rs2 : ID-stage sources
//   ex_rd/ex_mem_read/ex_redirect         : EX-stage load dest and redirect
//   mem_req/mem_ready                     : data-memory handshake
//   pc_stall, ifid_stall, ifid_clr, idex_stall, idex_clr,
//   exmem_stall, memwb_clr                : pipeline register controls
//   mem_timeout (pulse), mem_err (sticky) : memory wait watchdog
// Option HAZARD_PERF_EN adds perf_stall_cnt and perf_flush_cnt outputs.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ready,
`ifdef HAZARD_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_clr,
  output logic        idex_stall,
  output logic        idex_clr,
  output logic        exmem_stall,
  output logic        memwb_clr,
  output logic        mem_timeout,
  output logic        mem_err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          freeze, tmo, lu_hit, wait_rdy, flush;

  // A dropped request while waiting counts as completion.
  assign wait_rdy = mem_ready | ~mem_req;

  assign lu_hit = ex_mem_read & (|ex_rd) &
                  ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                   (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    freeze  = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_req & ~mem_ready) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          cnt_d   = CW'(1);
        end
      end
      MEM_WAIT: begin
        if (wait_rdy) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q < TMO) begin
          freeze = 1'b1;
          cnt_d  = cnt_q + CW'(1);
        end else begin
          tmo     = 1'b1;
          err_d   = 1'b1;
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_clr    = 1'b0;
    idex_stall  = 1'b0;
    idex_clr    = 1'b0;
    exmem_stall = 1'b0;
    memwb_clr   = 1'b0;
    flush       = 1'b0;
    if (!rst) begin
      priority case (1'b1)
        freeze: begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          memwb_clr   = 1'b1;
        end
        ex_redirect: begin
          ifid_clr = 1'b1;
          idex_clr = 1'b1;
          flush    = 1'b1;
        end
        lu_hit: begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_clr   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_timeout = tmo & ~rst;
  assign mem_err     = err_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + {31'd0, pc_stall};
      perf_flush_cnt <= perf_flush_cnt + {31'd0, flush};
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (MEM_TIMEOUT=4).
// Expected vectors: {pc_st,ifid_st,ifid_clr,idex_st,idex_clr,exmem_st,memwb_clr,tmo,err}
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic       mem_req, mem_ready;
  logic       pc_stall, ifid_stall, ifid_clr, idex_stall, idex_clr;
  logic       exmem_stall, memwb_clr, mem_timeout, mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [8:0] ZERO = 9'b000000000;
  localparam logic [8:0] FRZ  = 9'b110101100;
  localparam logic [8:0] LU   = 9'b110010000;
  localparam logic [8:0] RD   = 9'b001010000;
  localparam logic [8:0] TO   = 9'b000000010;
  localparam logic [8:0] ERR  = 9'b000000001;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_clr(ifid_clr),
    .idex_stall(idex_stall), .idex_clr(idex_clr),
    .exmem_stall(exmem_stall), .memwb_clr(memwb_clr),
    .mem_timeout(mem_timeout), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Check combinational outputs mid-cycle, then advance one clock.
  task automatic step(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    @(negedge clk);
    obs = {pc_stall, ifid_stall, ifid_clr, idex_stall, idex_clr,
           exmem_stall, memwb_clr, mem_timeout, mem_err};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    n_vec++;
    assert ((idex_stall & idex_clr) === 1'b0) else begin
      n_err++;
      $error("FAIL %s_inv: observed stall&clr=1 expected 0", tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = 0; ex_mem_read = 0; ex_redirect = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    idle();
    rst = 1; mem_req = 1; ex_redirect = 1;
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    step("reset", ZERO);
    rst = 0; idle();
    step("idle", ZERO);

    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    step("lu_rs1", LU);
    ex_mem_read = 0;
    step("lu_done", ZERO);
    idle(); ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1;
    step("lu_rs2", LU);
    id_rs1 = 7; id_uses_rs1 = 1;
    step("lu_both", LU);
    idle(); ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    step("x0", ZERO);
    ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 0;
    step("unused", ZERO);
    ex_mem_read = 0; id_uses_rs1 = 1;
    step("noload", ZERO);

    ex_mem_read = 1; ex_redirect = 1;
    step("redir_lu", RD);

    mem_req = 1; mem_ready = 0;
    step("frz1", FRZ);
    step("frz2", FRZ);
    step("frz3", FRZ);
    ex_redirect = 0; mem_ready = 1;
    step("release_lu", LU);
    idle(); mem_req = 1; mem_ready = 1;
    step("run_ready", ZERO);

    mem_ready = 0;
    step("drop_frz", FRZ);
    mem_req = 0;
    step("drop_rel", ZERO);
    mem_req = 1;
    step("drop_rerun", FRZ);
    mem_req = 0;
    step("drop_rel2", ZERO);

    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) step("to_frz", FRZ);
    step("to_pulse", TO);
    mem_req = 0;
    step("err_set", ERR);
    ex_redirect = 1;
    step("err_redir", RD | ERR);
    ex_redirect = 0;

    mem_req = 1;
    step("rst_frz1", FRZ | ERR);
    rst = 1;
    step("rst_mid", ZERO);
    rst = 0;
    for (int i = 0; i < 4; i++) step("post_frz", FRZ);
    step("post_pulse", TO);
    mem_req = 0;
    step("post_err", ERR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
